// File: rtl/boundary_pkg.sv
// Shared widths, FSM state, accumulator clear constants and corner helpers for boundary_tracker.
// Holds the BOUNDARY_SMOOTH_EN averaging helper used by the top when that macro is defined.
package boundary_pkg;

   localparam int COORD_W = 11;
   localparam int SD_W    = 12;
   localparam int COUNT_W = 20;

   typedef enum logic [1:0] {
      ACCUM  = 2'd0,
      DRAIN  = 2'd1,
      COMMIT = 2'd2
   } state_t;

   typedef struct packed {
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
   } corner_t;

   // Clear values chosen so the first marker pixel of a frame always wins every compare.
   localparam logic [SD_W-1:0]        S_MIN_CLR = 12'hFFF;
   localparam logic [SD_W-1:0]        S_MAX_CLR = 12'h000;
   localparam logic signed [SD_W-1:0] D_MAX_CLR = 12'sh800;
   localparam logic signed [SD_W-1:0] D_MIN_CLR = 12'sh7FF;
   localparam logic [COUNT_W-1:0]     COUNT_MAX = 20'hFFFFF;

   function automatic logic [COORD_W-1:0] smooth_coord(input logic [COORD_W-1:0] old_v,
                                                        input logic [COORD_W-1:0] new_v);
      logic [SD_W-1:0] sum;
      sum = {1'b0, old_v} + {1'b0, new_v} + 12'd1;
      return sum[SD_W-1:1];
   endfunction

   function automatic corner_t smooth_corner(input corner_t old_c, input corner_t new_c);
      corner_t res;
      res.x = smooth_coord(old_c.x, new_c.x);
      res.y = smooth_coord(old_c.y, new_c.y);
      return res;
   endfunction

endpackage

// File: rtl/marker_classify.sv
// Stage 1 of boundary_tracker: colour threshold for marker pixels, registered with the pixel position.
module marker_classify
   import boundary_pkg::*;
#(
   parameter logic [7:0] p_r_min  = 8'd160,
   parameter logic [7:0] p_gb_max = 8'd96
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               accept,
   input  logic               pix_valid,
   input  logic [COORD_W-1:0] pix_x,
   input  logic [COORD_W-1:0] pix_y,
   input  logic [7:0]         pix_R,
   input  logic [7:0]         pix_G,
   input  logic [7:0]         pix_B,
   output logic               marker,
   output corner_t            pos
);

   logic is_marker;

   assign is_marker = accept && pix_valid && (pix_R >= p_r_min)
                      && (pix_G <= p_gb_max) && (pix_B <= p_gb_max);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         marker <= 1'b0;
         pos    <= '0;
      end else begin
         marker <= is_marker;
         pos    <= '{x: pix_x, y: pix_y};
      end
   end

endmodule

// File: rtl/boundary_tracker.sv
// Per-frame marker corner tracker; commits the extreme corners at frame end.
// Define BOUNDARY_SMOOTH_EN to average each commit with the previous corner set.
//
// state  | meaning
// ACCUM  | stage-2 accumulators absorb marker pixels; frame_end moves to DRAIN
// DRAIN  | last pipelined pixel lands; commit decision and output load happen here
// COMMIT | corners_update visible; accumulators cleared on exit
module boundary_tracker
   import boundary_pkg::*;
#(
   parameter int         p_screen_width  = 640,
   parameter int         p_screen_height = 480,
   parameter int         p_min_count     = 64,
   parameter logic [7:0] p_r_min         = 8'd160,
   parameter logic [7:0] p_gb_max        = 8'd96
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               pix_valid,
   input  logic [COORD_W-1:0] pix_x,
   input  logic [COORD_W-1:0] pix_y,
   input  logic [7:0]         pix_R,
   input  logic [7:0]         pix_G,
   input  logic [7:0]         pix_B,
   input  logic               frame_end,
   output logic [COORD_W-1:0] top_left_x,
   output logic [COORD_W-1:0] top_left_y,
   output logic [COORD_W-1:0] top_right_x,
   output logic [COORD_W-1:0] top_right_y,
   output logic [COORD_W-1:0] bot_left_x,
   output logic [COORD_W-1:0] bot_left_y,
   output logic [COORD_W-1:0] bot_right_x,
   output logic [COORD_W-1:0] bot_right_y,
   output logic               corners_valid,
   output logic               corners_update,
   output logic [COUNT_W-1:0] marker_count
);

   localparam logic [COORD_W-1:0] X_MAX     = COORD_W'(p_screen_width - 1);
   localparam logic [COORD_W-1:0] Y_MAX     = COORD_W'(p_screen_height - 1);
   localparam logic [COUNT_W-1:0] MIN_COUNT = COUNT_W'(p_min_count);
   localparam corner_t TL_RST = '{x: '0,    y: '0};
   localparam corner_t TR_RST = '{x: X_MAX, y: '0};
   localparam corner_t BL_RST = '{x: '0,    y: Y_MAX};
   localparam corner_t BR_RST = '{x: X_MAX, y: Y_MAX};

   state_t  state, next_state;
   logic    do_commit;
   logic    marker_q;
   corner_t pos_q;

   logic [SD_W-1:0]        s_cur, s_min, s_max, s_min_nxt, s_max_nxt;
   logic signed [SD_W-1:0] d_cur, d_min, d_max, d_min_nxt, d_max_nxt;
   logic [COUNT_W-1:0]     count, count_nxt;
   corner_t acc_tl, acc_tr, acc_bl, acc_br;
   corner_t acc_tl_nxt, acc_tr_nxt, acc_bl_nxt, acc_br_nxt;
   corner_t out_tl, out_tr, out_bl, out_br;
   corner_t tl_new, tr_new, bl_new, br_new;

   marker_classify #(
      .p_r_min  (p_r_min),
      .p_gb_max (p_gb_max)
   ) u_classify (
      .clk       (clk),
      .reset     (reset),
      .accept    (state == ACCUM),
      .pix_valid (pix_valid),
      .pix_x     (pix_x),
      .pix_y     (pix_y),
      .pix_R     (pix_R),
      .pix_G     (pix_G),
      .pix_B     (pix_B),
      .marker    (marker_q),
      .pos       (pos_q)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ACCUM;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      do_commit  = 1'b0;
      case (state)
         ACCUM:  if (frame_end) next_state = DRAIN;
         DRAIN: begin
            next_state = COMMIT;
            do_commit  = (count_nxt >= MIN_COUNT);
         end
         COMMIT: next_state = ACCUM;
         default: next_state = ACCUM;
      endcase
   end

   assign s_cur = {1'b0, pos_q.x} + {1'b0, pos_q.y};
   assign d_cur = $signed({1'b0, pos_q.x}) - $signed({1'b0, pos_q.y});

   // Strict compares keep the earliest pixel in raster order on ties.
   always_comb begin
      s_min_nxt  = s_min;
      s_max_nxt  = s_max;
      d_min_nxt  = d_min;
      d_max_nxt  = d_max;
      acc_tl_nxt = acc_tl;
      acc_tr_nxt = acc_tr;
      acc_bl_nxt = acc_bl;
      acc_br_nxt = acc_br;
      count_nxt  = count;
      if (marker_q) begin
         if (s_cur < s_min) begin
            s_min_nxt  = s_cur;
            acc_tl_nxt = pos_q;
         end
         if (s_cur > s_max) begin
            s_max_nxt  = s_cur;
            acc_br_nxt = pos_q;
         end
         if (d_cur > d_max) begin
            d_max_nxt  = d_cur;
            acc_tr_nxt = pos_q;
         end
         if (d_cur < d_min) begin
            d_min_nxt  = d_cur;
            acc_bl_nxt = pos_q;
         end
         if (count != COUNT_MAX) count_nxt = count + 20'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset || state == COMMIT) begin
         if (!reset) begin
            s_min <= S_MIN_CLR;
         end else begin
            s_min <= S_MIN_CLR;
         end
         s_max  <= S_MAX_CLR;
         d_min  <= D_MIN_CLR;
         d_max  <= D_MAX_CLR;
         acc_tl <= '0;
         acc_tr <= '0;
         acc_bl <= '0;
         acc_br <= '0;
         count  <= '0;
      end else begin
         s_min  <= s_min_nxt;
         s_max  <= s_max_nxt;
         d_min  <= d_min_nxt;
         d_max  <= d_max_nxt;
         acc_tl <= acc_tl_nxt;
         acc_tr <= acc_tr_nxt;
         acc_bl <= acc_bl_nxt;
         acc_br <= acc_br_nxt;
         count  <= count_nxt;
      end
   end

`ifdef BOUNDARY_SMOOTH_EN
   // corners_valid marks that a previous commit exists to average against.
   assign tl_new = corners_valid ? smooth_corner(out_tl, acc_tl_nxt) : acc_tl_nxt;
   assign tr_new = corners_valid ? smooth_corner(out_tr, acc_tr_nxt) : acc_tr_nxt;
   assign bl_new = corners_valid ? smooth_corner(out_bl, acc_bl_nxt) : acc_bl_nxt;
   assign br_new = corners_valid ? smooth_corner(out_br, acc_br_nxt) : acc_br_nxt;
`else
   assign tl_new = acc_tl_nxt;
   assign tr_new = acc_tr_nxt;
   assign bl_new = acc_bl_nxt;
   assign br_new = acc_br_nxt;
`endif

   // Loaded at the DRAIN->COMMIT edge so results are visible during COMMIT.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_tl         <= TL_RST;
         out_tr         <= TR_RST;
         out_bl         <= BL_RST;
         out_br         <= BR_RST;
         corners_valid  <= 1'b0;
         corners_update <= 1'b0;
         marker_count   <= '0;
      end else begin
         corners_update <= do_commit;
         if (state == DRAIN) marker_count <= count_nxt;
         if (do_commit) begin
            out_tl        <= tl_new;
            out_tr        <= tr_new;
            out_bl        <= bl_new;
            out_br        <= br_new;
            corners_valid <= 1'b1;
         end
      end
   end

   assign top_left_x  = out_tl.x;
   assign top_left_y  = out_tl.y;
   assign top_right_x = out_tr.x;
   assign top_right_y = out_tr.y;
   assign bot_left_x  = out_bl.x;
   assign bot_left_y  = out_bl.y;
   assign bot_right_x = out_br.x;
   assign bot_right_y = out_br.y;

endmodule

// File: tb/tb_boundary_tracker.sv
// Directed self-checking bench for boundary_tracker; expectations are hand-computed corner sets.
module tb_boundary_tracker;

   logic        clk = 1'b0;
   logic        reset;
   logic        pix_valid;
   logic [10:0] pix_x, pix_y;
   logic [7:0]  pix_R, pix_G, pix_B;
   logic        frame_end;
   logic [10:0] top_left_x, top_left_y, top_right_x, top_right_y;
   logic [10:0] bot_left_x, bot_left_y, bot_right_x, bot_right_y;
   logic        corners_valid, corners_update;
   logic [19:0] marker_count;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   boundary_tracker dut (
      .clk            (clk),
      .reset          (reset),
      .pix_valid      (pix_valid),
      .pix_x          (pix_x),
      .pix_y          (pix_y),
      .pix_R          (pix_R),
      .pix_G          (pix_G),
      .pix_B          (pix_B),
      .frame_end      (frame_end),
      .top_left_x     (top_left_x),
      .top_left_y     (top_left_y),
      .top_right_x    (top_right_x),
      .top_right_y    (top_right_y),
      .bot_left_x     (bot_left_x),
      .bot_left_y     (bot_left_y),
      .bot_right_x    (bot_right_x),
      .bot_right_y    (bot_right_y),
      .corners_valid  (corners_valid),
      .corners_update (corners_update),
      .marker_count   (marker_count)
   );

   task automatic drive(input int x, input int y, input logic [7:0] r, input logic [7:0] g,
                        input logic [7:0] b, input logic v, input logic fe);
      @(negedge clk);
      pix_valid = v;
      pix_x     = 11'(x);
      pix_y     = 11'(y);
      pix_R     = r;
      pix_G     = g;
      pix_B     = b;
      frame_end = fe;
   endtask

   task automatic red(input int x, input int y);
      drive(x, y, 8'd255, 8'd0, 8'd0, 1'b1, 1'b0);
   endtask

   // frame_end in cycle N (optionally with a pixel); samples update at N+1..N+3.
   // dropv presents a marker pixel plus frame_end during DRAIN and COMMIT.
   task automatic finish_frame(input logic pv, input int px, input int py, input logic dropv,
                               output logic u1, output logic u2, output logic u3,
                               output logic [10:0] tlx1);
      drive(px, py, 8'd255, 8'd0, 8'd0, pv, 1'b1);
      drive(600, 400, 8'd255, 8'd0, 8'd0, dropv, dropv);
      u1   = corners_update;
      tlx1 = top_left_x;
      drive(600, 400, 8'd255, 8'd0, 8'd0, dropv, dropv);
      u2 = corners_update;
      drive(0, 0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
      u3 = corners_update;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset     = 1'b0;
      pix_valid = 1'b0;
      frame_end = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0; pix_valid = 1'b0; frame_end = 1'b0;
      pix_x = '0; pix_y = '0; pix_R = '0; pix_G = '0; pix_B = '0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({top_left_x, top_left_y} !== {11'd0, 11'd0})
         $display("FAIL reset_tl: got (%0d,%0d) expected (0,0)", top_left_x, top_left_y);
      else n_pass++;
      n_checks++;
      if ({top_right_x, top_right_y} !== {11'd639, 11'd0})
         $display("FAIL reset_tr: got (%0d,%0d) expected (639,0)", top_right_x, top_right_y);
      else n_pass++;
      n_checks++;
      if ({bot_left_x, bot_left_y} !== {11'd0, 11'd479})
         $display("FAIL reset_bl: got (%0d,%0d) expected (0,479)", bot_left_x, bot_left_y);
      else n_pass++;
      n_checks++;
      if ({bot_right_x, bot_right_y} !== {11'd639, 11'd479})
         $display("FAIL reset_br: got (%0d,%0d) expected (639,479)", bot_right_x, bot_right_y);
      else n_pass++;
      n_checks++;
      if (corners_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", corners_valid);
      else n_pass++;
      n_checks++;
      if (corners_update !== 1'b0) $display("FAIL reset_update: got %b expected 0", corners_update);
      else n_pass++;
      n_checks++;
      if (marker_count !== 20'd0) $display("FAIL reset_count: got %0d expected 0", marker_count);
      else n_pass++;
   endtask

   task automatic test_block();
      logic u1, u2, u3;
      logic [10:0] tlx1;
      for (int y = 50; y <= 59; y++)
         for (int x = 100; x <= 109; x++) red(x, y);
      finish_frame(1'b0, 0, 0, 1'b0, u1, u2, u3, tlx1);
      n_checks++;
      if (u1 !== 1'b0) $display("FAIL block_upd_n1: got %b expected 0", u1); else n_pass++;
      n_checks++;
      if (tlx1 !== 11'd0) $display("FAIL block_tl_early: got %0d expected 0", tlx1); else n_pass++;
      n_checks++;
      if (u2 !== 1'b1) $display("FAIL block_upd_n2: got %b expected 1", u2); else n_pass++;
      n_checks++;
      if (u3 !== 1'b0) $display("FAIL block_upd_n3: got %b expected 0", u3); else n_pass++;
      n_checks++;
      if ({top_left_x, top_left_y} !== {11'd100, 11'd50})
         $display("FAIL block_tl: got (%0d,%0d) expected (100,50)", top_left_x, top_left_y);
      else n_pass++;
      n_checks++;
      if ({top_right_x, top_right_y} !== {11'd109, 11'd50})
         $display("FAIL block_tr: got (%0d,%0d) expected (109,50)", top_right_x, top_right_y);
      else n_pass++;
      n_checks++;
      if ({bot_left_x, bot_left_y} !== {11'd100, 11'd59})
         $display("FAIL block_bl: got (%0d,%0d) expected (100,59)", bot_left_x, bot_left_y);
      else n_pass++;
      n_checks++;
      if ({bot_right_x, bot_right_y} !== {11'd109, 11'd59})
         $display("FAIL block_br: got (%0d,%0d) expected (109,59)", bot_right_x, bot_right_y);
      else n_pass++;
      n_checks++;
      if (marker_count !== 20'd100) $display("FAIL block_count: got %0d expected 100", marker_count);
      else n_pass++;
      n_checks++;
      if (corners_valid !== 1'b1) $display("FAIL block_valid: got %b expected 1", corners_valid);
      else n_pass++;
   endtask

   task automatic test_below_min();
      logic u1, u2, u3;
      logic [10:0] tlx1;
      for (int i = 0; i < 9; i++) red(i, 0);
      drive(20, 20, 8'd160, 8'd96, 8'd96, 1'b1, 1'b0);
      drive(30, 30, 8'd159, 8'd0, 8'd0, 1'b1, 1'b0);
      drive(31, 31, 8'd255, 8'd97, 8'd0, 1'b1, 1'b0);
      drive(32, 32, 8'd255, 8'd0, 8'd97, 1'b1, 1'b0);
      drive(33, 33, 8'd255, 8'd0, 8'd0, 1'b0, 1'b0);
      finish_frame(1'b0, 0, 0, 1'b0, u1, u2, u3, tlx1);
      n_checks++;
      if ((u1 | u2 | u3) !== 1'b0) $display("FAIL below_pulse: got %b%b%b expected 000", u1, u2, u3);
      else n_pass++;
      n_checks++;
      if (marker_count !== 20'd10) $display("FAIL below_count: got %0d expected 10", marker_count);
      else n_pass++;
      n_checks++;
      if ({top_left_x, top_left_y} !== {11'd100, 11'd50})
         $display("FAIL below_tl: got (%0d,%0d) expected (100,50)", top_left_x, top_left_y);
      else n_pass++;
      n_checks++;
      if ({bot_right_x, bot_right_y} !== {11'd109, 11'd59})
         $display("FAIL below_br: got (%0d,%0d) expected (109,59)", bot_right_x, bot_right_y);
      else n_pass++;
      n_checks++;
      if (corners_valid !== 1'b1) $display("FAIL below_valid: got %b expected 1", corners_valid);
      else n_pass++;
   endtask

   task automatic test_tie();
      logic u1, u2, u3;
      logic [10:0] tlx1;
      do_reset();
      red(5, 10);
      red(10, 5);
      for (int i = 0; i < 62; i++) red(200 + i, 200);
      finish_frame(1'b0, 0, 0, 1'b0, u1, u2, u3, tlx1);
      n_checks++;
      if (u2 !== 1'b1) $display("FAIL tie_upd_at_min: got %b expected 1", u2); else n_pass++;
      n_checks++;
      if (marker_count !== 20'd64) $display("FAIL tie_count: got %0d expected 64", marker_count);
      else n_pass++;
      n_checks++;
      if ({top_left_x, top_left_y} !== {11'd5, 11'd10})
         $display("FAIL tie_tl: got (%0d,%0d) expected (5,10)", top_left_x, top_left_y);
      else n_pass++;
      n_checks++;
      if ({bot_left_x, bot_left_y} !== {11'd5, 11'd10})
         $display("FAIL tie_bl: got (%0d,%0d) expected (5,10)", bot_left_x, bot_left_y);
      else n_pass++;
      n_checks++;
      if ({top_right_x, top_right_y} !== {11'd261, 11'd200})
         $display("FAIL tie_tr: got (%0d,%0d) expected (261,200)", top_right_x, top_right_y);
      else n_pass++;
      n_checks++;
      if ({bot_right_x, bot_right_y} !== {11'd261, 11'd200})
         $display("FAIL tie_br: got (%0d,%0d) expected (261,200)", bot_right_x, bot_right_y);
      else n_pass++;
   endtask

   task automatic test_frame_end_pixel();
      logic u1, u2, u3;
      logic [10:0] tlx1;
      do_reset();
      for (int i = 0; i < 63; i++) red(100 + i, 100);
      finish_frame(1'b1, 300, 300, 1'b1, u1, u2, u3, tlx1);
      n_checks++;
      if (u2 !== 1'b1) $display("FAIL fep_upd: got %b expected 1", u2); else n_pass++;
      n_checks++;
      if (marker_count !== 20'd64) $display("FAIL fep_count: got %0d expected 64", marker_count);
      else n_pass++;
      n_checks++;
      if ({bot_right_x, bot_right_y} !== {11'd300, 11'd300})
         $display("FAIL fep_br: got (%0d,%0d) expected (300,300)", bot_right_x, bot_right_y);
      else n_pass++;
      n_checks++;
      if ({top_left_x, top_left_y} !== {11'd100, 11'd100})
         $display("FAIL fep_tl: got (%0d,%0d) expected (100,100)", top_left_x, top_left_y);
      else n_pass++;
      // The pixels offered during DRAIN/COMMIT must not leak into the next frame.
      finish_frame(1'b0, 0, 0, 1'b0, u1, u2, u3, tlx1);
      n_checks++;
      if ((u1 | u2 | u3) !== 1'b0) $display("FAIL drop_pulse: got %b%b%b expected 000", u1, u2, u3);
      else n_pass++;
      n_checks++;
      if (marker_count !== 20'd0) $display("FAIL drop_count: got %0d expected 0", marker_count);
      else n_pass++;
      n_checks++;
      if ({bot_right_x, bot_right_y} !== {11'd300, 11'd300})
         $display("FAIL drop_br: got (%0d,%0d) expected (300,300)", bot_right_x, bot_right_y);
      else n_pass++;
   endtask

   task automatic test_reset_midframe();
      logic u1, u2, u3;
      logic [10:0] tlx1;
      for (int i = 0; i < 80; i++) red(10 + i, 20);
      @(negedge clk);
      #2;
      reset     = 1'b0;
      pix_valid = 1'b0;
      #1;
      n_checks++;
      if ({top_left_x, top_left_y} !== {11'd0, 11'd0})
         $display("FAIL midrst_tl: got (%0d,%0d) expected (0,0)", top_left_x, top_left_y);
      else n_pass++;
      n_checks++;
      if (corners_valid !== 1'b0) $display("FAIL midrst_valid: got %b expected 0", corners_valid);
      else n_pass++;
      n_checks++;
      if (marker_count !== 20'd0) $display("FAIL midrst_count: got %0d expected 0", marker_count);
      else n_pass++;
      @(negedge clk);
      reset = 1'b1;
      finish_frame(1'b0, 0, 0, 1'b0, u1, u2, u3, tlx1);
      n_checks++;
      if ((u1 | u2 | u3) !== 1'b0) $display("FAIL midrst_pulse: got %b%b%b expected 000", u1, u2, u3);
      else n_pass++;
      n_checks++;
      if (marker_count !== 20'd0) $display("FAIL midrst_frame_count: got %0d expected 0", marker_count);
      else n_pass++;
      n_checks++;
      if (corners_valid !== 1'b0) $display("FAIL midrst_frame_valid: got %b expected 0", corners_valid);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic u1, u2, u3;
      logic [10:0] tlx1;
      logic [21:0] exp_tl, exp_br;
`ifdef BOUNDARY_SMOOTH_EN
      exp_tl = {11'd105, 11'd56};
      exp_br = {11'd113, 11'd64};
`else
      exp_tl = {11'd110, 11'd61};
      exp_br = {11'd117, 11'd68};
`endif
      do_reset();
      for (int y = 50; y <= 59; y++)
         for (int x = 100; x <= 109; x++) red(x, y);
      finish_frame(1'b0, 0, 0, 1'b0, u1, u2, u3, tlx1);
      for (int y = 61; y <= 68; y++)
         for (int x = 110; x <= 117; x++) red(x, y);
      finish_frame(1'b0, 0, 0, 1'b0, u1, u2, u3, tlx1);
      n_checks++;
      if (u2 !== 1'b1) $display("FAIL b2b_upd: got %b expected 1", u2); else n_pass++;
      n_checks++;
      if ({top_left_x, top_left_y} !== exp_tl)
         $display("FAIL b2b_tl: got (%0d,%0d) expected (%0d,%0d)", top_left_x, top_left_y,
                  exp_tl[21:11], exp_tl[10:0]);
      else n_pass++;
      n_checks++;
      if ({bot_right_x, bot_right_y} !== exp_br)
         $display("FAIL b2b_br: got (%0d,%0d) expected (%0d,%0d)", bot_right_x, bot_right_y,
                  exp_br[21:11], exp_br[10:0]);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_block();
      test_below_min();
      test_tie();
      test_frame_end_pixel();
      test_reset_midframe();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/boundary_tracker.md
# boundary_tracker

Per-frame marker tracker that scans the incoming camera/VGA pixel stream, classifies marker-coloured pixels, and extracts the four projected corners of the marked region. At each frame end it commits the corner set that the downstream boundary-select/image-warp stage consumes on its top_left/top_right/bot_left/bot_right coordinate inputs. Corners are held stable for a whole frame so the downstream stage never sees a partial update.

## Interface
- p_screen_width, 640, visible width; sets reset/default corner x
- p_screen_height, 480, visible height; sets reset/default corner y
- p_min_count, 64, minimum marker pixels per frame for a commit
- p_r_min, 8'd160, marker requires R ≥ p_r_min
- p_gb_max, 8'd96, marker requires G ≤ p_gb_max and B ≤ p_gb_max

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- pix_valid  in  1  pixel qualifier
- pix_x  in  11  unsigned pixel column
- pix_y  in  11  unsigned pixel row
- pix_R, pix_G, pix_B  in  8 each  pixel colour
- frame_end  in  1  one-cycle pulse after last pixel of frame
- top_left_x/y, top_right_x/y, bot_left_x/y, bot_right_x/y  out  11 each  committed corners
- corners_valid  out  1  high once any frame has committed
- corners_update  out  1  one-cycle pulse on each commit
- marker_count  out  20  marker pixel count of last completed frame (saturating)

## Operation
- Stage 1 (register): marker = pix_valid & R≥p_r_min & G≤p_gb_max & B≤p_gb_max; x, y registered alongside.
- Stage 2 (accumulate), per marker pixel, strict compares (first pixel in raster order wins ties):
  - top_left: minimise s = x+y (12-bit unsigned)
  - bot_right: maximise s
  - top_right: maximise d = x−y (12-bit signed)
  - bot_left: minimise d
- count increments per marker pixel, saturates at 20'hFFFFF.
- FSM: ACCUM → DRAIN on frame_end; DRAIN → COMMIT (1 cycle); COMMIT → ACCUM (1 cycle).
- COMMIT: marker_count ← count always; if count ≥ p_min_count, load corners, pulse corners_update, set corners_valid; otherwise outputs and corners_valid unchanged, no pulse. Accumulators and count clear on exit from COMMIT.
- Accumulator clear values: s_min=12'hFFF, s_max=0, d_max=−2048, d_min=+2047, so any marker pixel replaces them.
- A pixel presented in the same cycle as frame_end is included in the frame.
- pix_valid during DRAIN/COMMIT: pixel dropped. frame_end during DRAIN/COMMIT: ignored.

## Timing
- Reset values: top_left=(0,0), top_right=(p_screen_width−1,0), bot_left=(0,p_screen_height−1), bot_right=(p_screen_width−1,p_screen_height−1); corners_valid=0, corners_update=0, marker_count=0; FSM=ACCUM.
- Pixel-to-accumulator latency: 2 cycles.
- frame_end at cycle N → outputs and corners_update change at edge N+2 (visible in cycle N+2); ACCUM again at N+3.
- Reset assertion mid-frame discards all accumulation immediately; no commit.
- Upstream guarantees ≥2 blanking cycles after frame_end.

## Configuration
- BOUNDARY_SMOOTH_EN defined: each commit after the first writes corner = (old + new + 1) >> 1 per coordinate (12-bit intermediate); the first commit after reset loads raw values.
- Undefined: each commit loads raw values.

## Structure
- boundary_pkg: coordinate width (11), sum/diff width (12), count width (20), FSM state enum {ACCUM, DRAIN, COMMIT}, accumulator clear constants.
- Sub-module marker_classify: stage-1 colour threshold plus x/y/valid register.

## Test plan
- Reset only → corners (0,0),(639,0),(0,479),(639,479); corners_valid=0.
- 100-pixel red block spanning x 100..109, y 50..59, then frame_end at N → at N+2 corners (100,50),(109,50),(100,59),(109,59); one corners_update pulse; marker_count=100.
- 10 marker pixels then frame_end → marker_count=10; corners unchanged; no pulse.
- Tie: marker pixels (5,10) then (10,5) → top_left=(5,10).
- Pixel with frame_end in same cycle at (300,300) alone plus 63 others → included; bot_right=(300,300).
- With BOUNDARY_SMOOTH_EN: commit top_left (100,50) then (110,61) → (105,56).
